biu_master_arb: RTL and testbench
=================================

Name: biu_master_arb

Overview:
Second-generation bus interface unit master for the shared tri-state address/data/control bus.
- Adds request/grant arbitration so several masters can share one bus.
- Adds a response timeout with bus-error reporting, so an unmapped address can no longer hang the FSM.
- Keeps the same master-side request interface; it sits between a CPU/DMA master and the bus arbiter.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width
TIMEOUT_CYCLES, 16, max WAIT_RSP cycles before bus error (>=2)
RETRY_MAX, 2, reissue attempts after timeout (used only with BIU_MASTER_RETRY_EN)

Ports:
clk  input  1  clock, all logic on rising edge
n_rst  input  1  asynchronous active-low reset
bus_address  inout  ADDR_WIDTH  shared bus address
bus_data  inout  DATA_WIDTH  shared bus data
bus_control  inout  2  [1]=rnw (1=read), [0]=data_valid
o_bus_req  output  1  bus request to arbiter
i_bus_gnt  input  1  bus grant from arbiter
i_address  input  ADDR_WIDTH  request address
i_data_out  input  DATA_WIDTH  write data
i_rnw  input  1  1=read, 0=write
i_en  input  1  request strobe, accepted only when idle
o_data_in  output  DATA_WIDTH  read data, 0 unless o_data_valid
o_data_valid  output  1  read data valid, one cycle
o_busy  output  1  state != IDLE
o_bus_err  output  1  one-cycle pulse on final timeout
o_err_irq  output  1  sticky error interrupt
o_err_addr  output  ADDR_WIDTH  address of last failed request
i_err_clr  input  1  clears o_err_irq

Behaviour:
- Reset (async, n_rst low, any state): state=IDLE; address/data/rnw registers=0; timeout counter=0; o_err_irq=0; o_err_addr=0.
- Outputs during reset: o_bus_req=0, o_busy=0, o_data_valid=0, o_bus_err=0; all bus pins released to 'z. Reset mid-transaction abandons it silently.
- The arbiter owns idle bus pull-low. This master drives the bus only in SEND_REQ, otherwise 'z.
- IDLE:
  - i_en=1 latches i_address/i_data_out/i_rnw and moves to WAIT_GNT.
  - i_en in any other state is ignored.
- WAIT_GNT:
  - o_bus_req=1.
  - i_bus_gnt=1 -> SEND_REQ next cycle.
  - No grant timeout.
- SEND_REQ: drives {address_q, data_q, rnw_q, 1'b1}.
  - Next state: rnw_q ? WAIT_RSP : WAIT_REQ.
  - Timeout counter cleared.
- WAIT_REQ: one turnaround cycle, bus 'z, then IDLE. Write latency i_en -> IDLE = 3 cycles + grant wait.
- WAIT_RSP: bus 'z; counter increments each cycle.
  - bus_control[0]=1 -> o_data_valid=1 and o_data_in=bus_data combinationally that cycle, then IDLE.
  - Counter==TIMEOUT_CYCLES-1 with no valid -> timeout, go to IDLE.
  - On timeout: o_bus_err=1 that cycle; o_err_addr<=address_q; o_err_irq<=1.
  - Valid and timeout in the same cycle: valid wins, no error.
- o_bus_req=1 in WAIT_GNT, SEND_REQ, WAIT_RSP and WAIT_REQ. The bus is held through turnaround; the arbiter must not revoke grant while o_bus_req=1. A grant drop mid-transaction is ignored.
- o_err_irq: set has priority over simultaneous i_err_clr.
- Counter width $clog2(TIMEOUT_CYCLES); the counter never wraps (saturates in the terminal cycle).

Optional Feature:
BIU_MASTER_RETRY_EN
- Defined:
  - Timeout returns to WAIT_GNT (re-arbitrates) and increments a retry count.
  - o_bus_err, o_err_irq and o_err_addr update only on the timeout that occurs after RETRY_MAX retries.
  - Retry count clears on entry from IDLE.
- Undefined: no retry logic; the first timeout is final.

Decomposition:
- Package biu_pkg:
  - biu_master_state_t enum (IDLE, WAIT_GNT, SEND_REQ, WAIT_RSP, WAIT_REQ), one-hot encoded.
  - localparams BUS_CTRL_RNW=1 and BUS_CTRL_VALID=0.
- Sub-module biu_timeout_counter:
  - Parameter LIMIT.
  - Inputs clk, n_rst, clr, en.
  - Output o_expire, high when count==LIMIT-1 and en.

Test Plan:
- Write A=0x100, D=0xDEAD, grant after 3 cycles -> bus shows {0x100, 0xDEAD, 2'b01} for exactly one cycle; o_busy high 6 cycles; no o_data_valid.
- Read A=0x200, slave asserts valid with 0xBEEF 4 cycles into WAIT_RSP -> o_data_valid one pulse, o_data_in=0xBEEF, then IDLE; o_data_in=0 all other cycles.
- Read, no slave response, TIMEOUT_CYCLES=16 -> o_bus_err pulses on 16th WAIT_RSP cycle; o_err_irq=1; o_err_addr=0x200.
- Valid on the exact terminal timeout cycle -> data returned, o_bus_err=0, o_err_irq unchanged.
- i_err_clr same cycle as new timeout -> o_err_irq remains 1. i_err_clr alone -> o_err_irq=0 next cycle.
- n_rst pulsed mid-WAIT_RSP -> all outputs 0 and bus 'z immediately. With BIU_MASTER_RETRY_EN, RETRY_MAX=2 -> three request phases, one o_bus_err.

Source files
------------

// File: rtl/biu_pkg.sv
// Shared types and bus-control bit positions for the bus interface unit master.
package biu_pkg;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    WAIT_GNT = 5'b00010,
    SEND_REQ = 5'b00100,
    WAIT_RSP = 5'b01000,
    WAIT_REQ = 5'b10000
  } biu_master_state_t;

  localparam int BUS_CTRL_RNW   = 1;
  localparam int BUS_CTRL_VALID = 0;

endpackage

// File: rtl/biu_timeout_counter.sv
// Response timeout counter: counts enabled cycles and flags the terminal one.
module biu_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic o_expire
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_expire  = en && w_at_last;

  // Holds at LAST rather than wrapping, so a late valid can never alias a fresh count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !w_at_last) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/biu_master_arb.sv
// Arbitrated bus master with response timeout and sticky error reporting.
// Optional re-arbitrating retry on timeout is enabled by defining BIU_MASTER_RETRY_EN.
module biu_master_arb
  import biu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
`ifdef BIU_MASTER_RETRY_EN
  parameter int RETRY_MAX      = 2,
`endif
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  inout  wire  [ADDR_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  inout  wire  [1:0]            bus_control,
  output logic                  o_bus_req,
  input  logic                  i_bus_gnt,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data_out,
  input  logic                  i_rnw,
  input  logic                  i_en,
  output logic [DATA_WIDTH-1:0] o_data_in,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_bus_err,
  output logic                  o_err_irq,
  output logic [ADDR_WIDTH-1:0] o_err_addr,
  input  logic                  i_err_clr
);

  biu_master_state_t r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_rnw;
  logic                  r_err_irq;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  logic       w_drive;
  logic       w_rsp_valid;
  logic       w_expire;
  logic       w_final;
  logic       w_retry_inc;
  logic [1:0] w_ctrl_out;

  assign w_drive     = (r_state == SEND_REQ);
  assign w_rsp_valid = bus_control[BUS_CTRL_VALID];

  always_comb begin
    w_ctrl_out                 = '0;
    w_ctrl_out[BUS_CTRL_RNW]   = r_rnw;
    w_ctrl_out[BUS_CTRL_VALID] = 1'b1;
  end

  assign bus_address = w_drive ? r_address  : 'z;
  assign bus_data    = w_drive ? r_data     : 'z;
  assign bus_control = w_drive ? w_ctrl_out : 'z;

  biu_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (r_state == SEND_REQ),
    .en       (r_state == WAIT_RSP),
    .o_expire (w_expire)
  );

`ifdef BIU_MASTER_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 2);
  logic [RW-1:0] r_retry;

  // Only the timeout after the last allowed reissue is reported.
  assign w_final = (r_retry == RW'(RETRY_MAX));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_retry <= '0;
    end else if (r_state == IDLE) begin
      r_retry <= '0;
    end else if (w_retry_inc) begin
      r_retry <= r_retry + RW'(1);
    end
  end
`else
  assign w_final = 1'b1;
`endif

  always_comb begin
    w_next_state = r_state;
    o_data_valid = 1'b0;
    o_data_in    = '0;
    o_bus_err    = 1'b0;
    w_retry_inc  = 1'b0;
    case (r_state)
      IDLE:     if (i_en) w_next_state = WAIT_GNT;
      WAIT_GNT: if (i_bus_gnt) w_next_state = SEND_REQ;
      SEND_REQ: w_next_state = r_rnw ? WAIT_RSP : WAIT_REQ;
      WAIT_REQ: w_next_state = IDLE;
      WAIT_RSP: begin
        // A response on the terminal cycle still wins over the timeout.
        if (w_rsp_valid) begin
          o_data_valid = 1'b1;
          o_data_in    = bus_data;
          w_next_state = IDLE;
        end else if (w_expire) begin
          if (w_final) begin
            o_bus_err    = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_retry_inc  = 1'b1;
            w_next_state = WAIT_GNT;
          end
        end
      end
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_address  <= '0;
      r_data     <= '0;
      r_rnw      <= 1'b0;
      r_err_irq  <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && i_en) begin
        r_address <= i_address;
        r_data    <= i_data_out;
        r_rnw     <= i_rnw;
      end
      if (o_bus_err) begin
        r_err_irq  <= 1'b1;
        r_err_addr <= r_address;
      end else if (i_err_clr) begin
        r_err_irq <= 1'b0;
      end
    end
  end

  assign o_busy     = (r_state != IDLE);
  assign o_bus_req  = (r_state != IDLE);
  assign o_err_irq  = r_err_irq;
  assign o_err_addr = r_err_addr;

endmodule

// File: tb/tb_biu_master_arb.sv
// Self-checking bench for biu_master_arb: timeline-driven arbiter/slave plus a bus scoreboard.
module tb_biu_master_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef BIU_MASTER_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif
  localparam int ATTEMPTS = RETRIES + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    ctrl;
  } req_t;

  typedef struct packed {
    logic          is_err;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic n_rst;
  logic i_bus_gnt, i_rnw, i_en, i_err_clr;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_data_out;
  logic o_bus_req, o_data_valid, o_busy, o_bus_err, o_err_irq;
  logic [DW-1:0] o_data_in;
  logic [AW-1:0] o_err_addr;

  wire [AW-1:0] bus_address;
  wire [DW-1:0] bus_data;
  wire [1:0]    bus_control;

  logic          tb_drv;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;
  logic [1:0]    tb_ctrl;

  assign bus_address = tb_drv ? tb_addr : 'z;
  assign bus_data    = tb_drv ? tb_data : 'z;
  assign bus_control = tb_drv ? tb_ctrl : 'z;

  int n_checks = 0;
  int n_fail   = 0;

  req_t req_q[$];
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  biu_master_arb #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .bus_address  (bus_address),
    .bus_data     (bus_data),
    .bus_control  (bus_control),
    .o_bus_req    (o_bus_req),
    .i_bus_gnt    (i_bus_gnt),
    .i_address    (i_address),
    .i_data_out   (i_data_out),
    .i_rnw        (i_rnw),
    .i_en         (i_en),
    .o_data_in    (o_data_in),
    .o_data_valid (o_data_valid),
    .o_busy       (o_busy),
    .o_bus_err    (o_bus_err),
    .o_err_irq    (o_err_irq),
    .o_err_addr   (o_err_addr),
    .i_err_clr    (i_err_clr)
  );

  // Scoreboard: request phases appear when the bench is not driving; responses pop in order.
  always @(negedge clk) begin
    if (n_rst) begin
      if (!o_data_valid) begin
        n_checks++;
        if (o_data_in !== '0) begin
          n_fail++;
          $display("FAIL data_in_idle: got %h want 0", o_data_in);
        end
      end
      if (!tb_drv && bus_control[0] === 1'b1) begin
        n_checks++;
        if (req_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_phase: unexpected phase addr=%h data=%h ctrl=%b want none",
                   bus_address, bus_data, bus_control);
        end else begin
          req_t e;
          e = req_q.pop_front();
          if ({bus_address, bus_data, bus_control} !== e) begin
            n_fail++;
            $display("FAIL req_phase: got %h/%h/%b want %h/%h/%b",
                     bus_address, bus_data, bus_control, e.addr, e.data, e.ctrl);
          end
        end
      end
      if (o_data_valid || o_bus_err) begin
        n_checks++;
        if (rsp_q.size() == 0) begin
          n_fail++;
          $display("FAIL response: unexpected valid=%b err=%b want none", o_data_valid, o_bus_err);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          if (o_bus_err !== r.is_err || o_data_valid !== !r.is_err ||
              (!r.is_err && o_data_in !== r.data)) begin
            n_fail++;
            $display("FAIL response: got err=%b valid=%b data=%h want err=%b data=%h",
                     o_bus_err, o_data_valid, o_data_in, r.is_err, r.data);
          end
        end
      end
    end
  end

  // Timeline stimulus: k=0 is the first WAIT_GNT cycle; grant is presented from cycle gnt_wait.
  task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic rnw,
                         input int gnt_wait, input int rsp_k, input logic [DW-1:0] rsp_data,
                         input int clr_k, input int en_k, input int n_phases, input int exp_rsp,
                         output int busy, output int phases, output int valid_k, output int err_k);
    req_t e;
    rsp_t r;
    bit done = 0;
    busy = 0; phases = 0; valid_k = -1; err_k = -1;
    e.addr = addr; e.data = data; e.ctrl = {rnw, 1'b1};
    for (int p = 0; p < n_phases; p++) req_q.push_back(e);
    if (exp_rsp == 1) begin r.is_err = 1'b0; r.data = rsp_data; rsp_q.push_back(r); end
    if (exp_rsp == 2) begin r.is_err = 1'b1; r.data = '0; rsp_q.push_back(r); end
    i_address = addr; i_data_out = data; i_rnw = rnw; i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0;
    for (int k = 0; k < 200; k++) begin
      i_bus_gnt = (k >= gnt_wait);
      tb_drv    = (k == rsp_k);
      tb_addr   = '0;
      tb_data   = rsp_data;
      tb_ctrl   = 2'b01;
      i_err_clr = (k == clr_k);
      i_en      = (k == en_k);
      if (k == en_k) begin
        i_address = 32'hF00; i_data_out = 32'h5555; i_rnw = ~rnw;
      end
      @(negedge clk);
      if (!o_busy) begin done = 1; break; end
      busy++;
      if (!tb_drv && bus_control[0] === 1'b1) phases++;
      if (o_data_valid) valid_k = k;
      if (o_bus_err) err_k = k;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_bus_gnt = 1'b0; tb_drv = 1'b0; i_err_clr = 1'b0; i_en = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL txn_done: busy still high after 200 cycles, want idle");
    end
    $display("txn %s addr=%h busy=%0d phases=%0d valid_k=%0d err_k=%0d irq=%b",
             rnw ? "RD" : "WR", addr, busy, phases, valid_k, err_k, o_err_irq);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    i_bus_gnt = 0; i_rnw = 0; i_en = 0; i_err_clr = 0; i_address = '0; i_data_out = '0;
    tb_drv = 0; tb_addr = '0; tb_data = '0; tb_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_bus_req, o_busy, o_data_valid, o_bus_err, o_err_irq} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
               {o_bus_req, o_busy, o_data_valid, o_bus_err, o_err_irq});
    end
    n_checks++;
    if (o_err_addr !== '0 || o_data_in !== '0) begin
      n_fail++;
      $display("FAIL reset_values: err_addr=%h data_in=%h want 0/0", o_err_addr, o_data_in);
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_write();
    int busy, ph, vk, ek;
    run_txn(32'h100, 32'hDEAD, 1'b0, 3, -1, '0, -1, 1, 1, 0, busy, ph, vk, ek);
    n_checks++;
    if (busy !== 6) begin n_fail++; $display("FAIL write_busy: got %0d want 6", busy); end
    n_checks++;
    if (ph !== 1) begin n_fail++; $display("FAIL write_phases: got %0d want 1", ph); end
    n_checks++;
    if (vk !== -1) begin n_fail++; $display("FAIL write_valid: got k=%0d want none", vk); end
  endtask

  task automatic test_read();
    int busy, ph, vk, ek;
    run_txn(32'h200, 32'h0, 1'b1, 0, 1 + 4, 32'hBEEF, -1, -1, 1, 1, busy, ph, vk, ek);
    n_checks++;
    if (vk !== 5) begin n_fail++; $display("FAIL read_valid_k: got %0d want 5", vk); end
    n_checks++;
    if (busy !== 6) begin n_fail++; $display("FAIL read_busy: got %0d want 6", busy); end
    n_checks++;
    if (ek !== -1) begin n_fail++; $display("FAIL read_err: got k=%0d want none", ek); end
  endtask

  task automatic test_timeout();
    int busy, ph, vk, ek;
    int exp_busy = 2 + (TO + 1) + RETRIES * (TO + 2);
    run_txn(32'h200, 32'h0, 1'b1, 1, -1, '0, -1, -1, ATTEMPTS, 2, busy, ph, vk, ek);
    n_checks++;
    if (ek !== exp_busy - 1) begin
      n_fail++; $display("FAIL timeout_k: got %0d want %0d", ek, exp_busy - 1);
    end
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++; $display("FAIL timeout_busy: got %0d want %0d", busy, exp_busy);
    end
    n_checks++;
    if (ph !== ATTEMPTS) begin
      n_fail++; $display("FAIL timeout_phases: got %0d want %0d", ph, ATTEMPTS);
    end
    n_checks++;
    if (o_err_irq !== 1'b1 || o_err_addr !== 32'h200) begin
      n_fail++; $display("FAIL timeout_irq: got irq=%b addr=%h want 1/00000200", o_err_irq, o_err_addr);
    end
  endtask

  task automatic test_valid_on_terminal();
    int busy, ph, vk, ek;
    run_txn(32'h300, 32'h0, 1'b1, 0, 1 + TO, 32'h1234, -1, -1, 1, 1, busy, ph, vk, ek);
    n_checks++;
    if (vk !== 1 + TO || ek !== -1) begin
      n_fail++; $display("FAIL terminal_valid: got valid_k=%0d err_k=%0d want %0d/-1", vk, ek, 1 + TO);
    end
    n_checks++;
    if (o_err_irq !== 1'b1 || o_err_addr !== 32'h200) begin
      n_fail++; $display("FAIL terminal_irq: got irq=%b addr=%h want 1/00000200", o_err_irq, o_err_addr);
    end
  endtask

  task automatic test_err_clr();
    int busy, ph, vk, ek;
    int exp_k = TO + 1 + RETRIES * (TO + 2);
    run_txn(32'h400, 32'h0, 1'b1, 0, -1, '0, exp_k, -1, ATTEMPTS, 2, busy, ph, vk, ek);
    n_checks++;
    if (ek !== exp_k) begin n_fail++; $display("FAIL clr_timeout_k: got %0d want %0d", ek, exp_k); end
    n_checks++;
    if (o_err_irq !== 1'b1 || o_err_addr !== 32'h400) begin
      n_fail++; $display("FAIL clr_set_priority: got irq=%b addr=%h want 1/00000400", o_err_irq, o_err_addr);
    end
    i_err_clr = 1'b1;
    @(posedge clk); #1;
    i_err_clr = 1'b0;
    n_checks++;
    if (o_err_irq !== 1'b0) begin n_fail++; $display("FAIL clr_alone: got irq=%b want 0", o_err_irq); end
    n_checks++;
    if (o_err_addr !== 32'h400) begin
      n_fail++; $display("FAIL clr_addr_kept: got %h want 00000400", o_err_addr);
    end
  endtask

  task automatic test_back_to_back();
    int busy, ph, vk, ek;
    run_txn(32'h104, 32'h1111, 1'b0, 0, -1, '0, -1, 1, 1, 0, busy, ph, vk, ek);
    n_checks++;
    if (busy !== 3) begin n_fail++; $display("FAIL b2b_write_busy: got %0d want 3", busy); end
    run_txn(32'h108, 32'h2222, 1'b1, 2, 3 + 1, 32'hCAFE, -1, 2, 1, 1, busy, ph, vk, ek);
    n_checks++;
    if (busy !== 5 || vk !== 4) begin
      n_fail++; $display("FAIL b2b_read: got busy=%0d valid_k=%0d want 5/4", busy, vk);
    end
  endtask

  task automatic test_reset_mid();
    req_t e;
    e.addr = 32'h500; e.data = 32'h0; e.ctrl = 2'b11;
    req_q.push_back(e);
    i_address = 32'h500; i_data_out = '0; i_rnw = 1'b1; i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0; i_bus_gnt = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: busy=%b want 1", o_busy); end
    n_rst = 1'b0;
    tb_drv = 1'b1; tb_addr = 32'h5A5A5A5A; tb_data = 32'hA5A5A5A5; tb_ctrl = 2'b10;
    #1;
    n_checks++;
    if ({o_bus_req, o_busy, o_data_valid, o_bus_err, o_err_irq} !== 5'b0 ||
        o_err_addr !== '0 || o_data_in !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: flags=%b err_addr=%h data_in=%h want 0",
               {o_bus_req, o_busy, o_data_valid, o_bus_err, o_err_irq}, o_err_addr, o_data_in);
    end
    n_checks++;
    if (bus_address !== 32'h5A5A5A5A || bus_data !== 32'hA5A5A5A5 || bus_control !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_bus_released: got %h/%h/%b want 5a5a5a5a/a5a5a5a5/10",
               bus_address, bus_data, bus_control);
    end
    @(posedge clk); #1;
    tb_drv = 1'b0; i_bus_gnt = 1'b0;
    n_rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (o_busy !== 1'b0 || o_bus_req !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: busy=%b req=%b want 0/0", o_busy, o_bus_req);
    end
    $display("txn RD addr=00000500 abandoned by reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_valid_on_terminal();
    test_err_clr();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: req left=%0d rsp left=%0d want 0/0", req_q.size(), rsp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
